// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared state encoding, opcode constants and counter sizing for the hazard controller.
package pipe_hazard_ctrl_pkg;
  typedef enum logic [2:0] {
    HZ_RUN      = 3'd0,
    HZ_MAC_BUSY = 3'd1,
    HZ_DRAIN    = 3'd2,
    HZ_HALTED   = 3'd3
  } hz_state_e;
  localparam logic [3:0] MAC_ALU = 4'd10;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  function automatic int cnt_w(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-side hazard inputs and pipeline-register controls of the sequencer.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic             stall_check;
  logic             br;
  logic [3:0]       id_alu_op;
  logic             halt_req;
  logic             halt_ack;
  logic             pc_we;
  logic             pc_sel;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic             ex_hold;
  logic [2:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output stall_check, br, id_alu_op, halt_req,
    input  halt_ack, pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, ex_hold, ctrl_state, stall_cnt, flush_cnt
  );
  modport slave (
    input  stall_check, br, id_alu_op, halt_req,
    output halt_ack, pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, ex_hold, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_cnt.sv
// hz_down_counter: loadable down counter shared by the MAC occupancy and drain phases.
module hz_down_counter #(parameter int W = 3) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = ld_i ? ld_val_i : (dec_i ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for load-use bubbles, branch flushes, MAC occupancy and debug halt/drain.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MAC_LATENCY = 3,
  parameter int DRAIN_CYC   = 3,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipe_hazard_ctrl_if.slave    bus
);
  localparam int CW = cnt_w(MAC_LATENCY, DRAIN_CYC);
  hz_state_e state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [CW-1:0] ld_val, cnt;
  logic ld, dec, halt_ack, pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, ex_hold;
  hz_down_counter #(.W(CW)) u_cnt (
    .clk(clk), .reset_n(reset_n), .ld_i(ld), .ld_val_i(ld_val), .dec_i(dec), .cnt_o(cnt)
  );
  always_comb begin
    state_d    = state_q;
    ld         = 1'b0;
    ld_val     = '0;
    dec        = 1'b0;
    halt_ack   = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    ex_hold    = 1'b0;
    case (state_q)
      HZ_RUN: begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        if (bus.halt_req) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          ld         = 1'b1;
          ld_val     = CW'(DRAIN_CYC - 1);
          state_d    = HZ_DRAIN;
        end else if (bus.stall_check) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end else if (bus.br) begin
          // the NOP load into IF/ID takes the register, so its write enable drops
          pc_sel     = 1'b1;
          ifid_flush = 1'b1;
          ifid_we    = 1'b0;
        end else if (bus.id_alu_op == MAC_ALU && MAC_LATENCY > 1) begin
          ld      = 1'b1;
          ld_val  = CW'(MAC_LATENCY - 1);
          state_d = HZ_MAC_BUSY;
        end
      end
      HZ_MAC_BUSY: begin
        idex_flush = 1'b1;
        ex_hold    = 1'b1;
        dec        = 1'b1;
        state_d    = cnt == CW'(1) ? HZ_RUN : HZ_MAC_BUSY;
      end
      HZ_DRAIN: begin
        idex_flush = 1'b1;
        dec        = cnt != '0;
        state_d    = cnt == '0 ? HZ_HALTED : HZ_DRAIN;
      end
      HZ_HALTED: begin
        halt_ack = 1'b1;
        state_d  = bus.halt_req ? HZ_HALTED : HZ_RUN;
      end
      default: state_d = HZ_RUN;
    endcase
  end
  assign stall_cnt_d = stall_cnt_q + CNT_W'(!pc_we);
  assign flush_cnt_d = flush_cnt_q + CNT_W'(ifid_flush);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= HZ_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  // RUN enables are Mealy on a live state, so reset has to mask them explicitly
  assign bus.halt_ack   = reset_n & halt_ack;
  assign bus.pc_we      = reset_n & pc_we;
  assign bus.pc_sel     = reset_n & pc_sel;
  assign bus.ifid_we    = reset_n & ifid_we;
  assign bus.ifid_flush = reset_n & ifid_flush;
  assign bus.idex_flush = reset_n & idex_flush;
  assign bus.ex_hold    = reset_n & ex_hold;
  assign bus.ctrl_state = state_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus against a cycle-level behavioural model of the sequencer.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;
  localparam int MACL = 3;
  localparam int DRN  = 3;
  localparam int CW   = 32;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus();
  pipe_hazard_ctrl #(.MAC_LATENCY(MACL), .DRAIN_CYC(DRN), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  int total = 0;
  int bad = 0;
  int hold_left, drain_left;
  bit halted;
  logic [CW-1:0] m_stall, m_flush;
  task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s: got %0h want %0h", tag, what, obs, exp);
    end
  endtask
  function automatic logic [6:0] ctl();
    return {bus.halt_ack, bus.pc_we, bus.pc_sel, bus.ifid_we, bus.ifid_flush, bus.idex_flush, bus.ex_hold};
  endfunction
  task automatic model_reset();
    hold_left = 0;
    drain_left = 0;
    halted = 0;
    m_stall = '0;
    m_flush = '0;
  endtask
  task automatic drive(input bit s, input bit b, input logic [3:0] op, input bit h);
    bus.stall_check = s;
    bus.br = b;
    bus.id_alu_op = op;
    bus.halt_req = h;
  endtask
  // one clock cycle: drive, compare against the model, then advance the model
  task automatic cyc(input string tag, input bit s, input bit b, input logic [3:0] op, input bit h);
    logic [6:0] e;
    int st;
    bit fl;
    @(negedge clk);
    drive(s, b, op, h);
    #1;
    fl = 0;
    if (hold_left > 0) begin
      e = 7'b0000011; st = 1; hold_left--;
    end else if (drain_left > 0) begin
      e = 7'b0000010; st = 2; drain_left--;
      if (drain_left == 0) halted = 1;
    end else if (halted) begin
      e = 7'b1000000; st = 3;
      if (!h) halted = 0;
    end else begin
      st = 0;
      if (h) begin
        e = 7'b0000010; drain_left = DRN;
      end else if (s) e = 7'b0000010;
      else if (b) begin
        e = 7'b0110100; fl = 1;
      end else begin
        e = 7'b0101000;
        if (op == MAC_ALU) hold_left = MACL - 1;
      end
    end
    chk(tag, "ctl", ctl(), e);
    chk(tag, "state", bus.ctrl_state, 64'(st));
    chk(tag, "stall_cnt", bus.stall_cnt, m_stall);
    chk(tag, "flush_cnt", bus.flush_cnt, m_flush);
    m_stall = m_stall + CW'(!e[5]);
    m_flush = m_flush + CW'(fl);
  endtask
  initial begin
    bit h;
    model_reset();
    drive(0, 0, 4'd0, 0);
    #2;
    chk("reset", "ctl", ctl(), 7'd0);
    chk("reset", "state", bus.ctrl_state, 64'd0);
    chk("reset", "stall_cnt", bus.stall_cnt, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc("idle", 0, 0, 4'd0, 0);
    cyc("loaduse", 1, 0, 4'd0, 0);
    cyc("loaduse_after", 0, 0, 4'd0, 0);
    cyc("branch", 0, 1, 4'd0, 0);
    cyc("branch_after", 0, 0, 4'd0, 0);
    cyc("br_and_stall", 1, 1, 4'd0, 0);
    cyc("mac_issue", 0, 0, MAC_ALU, 0);
    cyc("mac_hold1", 0, 1, 4'd0, 0);
    cyc("mac_hold2", 1, 1, 4'd0, 0);
    cyc("mac_done", 0, 0, 4'd0, 0);
    cyc("halt_req", 0, 0, 4'd0, 1);
    for (int i = 0; i < DRN; i++) cyc("drain", 0, 0, 4'd0, 1);
    cyc("halted", 0, 1, MAC_ALU, 1);
    cyc("unhalt", 0, 0, 4'd0, 0);
    cyc("resume", 0, 0, 4'd0, 0);
    cyc("mac_then_halt", 0, 0, MAC_ALU, 0);
    cyc("mac_busy_halt1", 0, 0, 4'd0, 1);
    cyc("mac_busy_halt2", 0, 0, 4'd0, 1);
    for (int i = 0; i < DRN + 2; i++) cyc("post_mac_halt", 0, 0, 4'd0, 1);
    cyc("post_mac_unhalt", 0, 0, 4'd0, 0);
    cyc("halt_short", 0, 0, 4'd0, 1);
    for (int i = 0; i < DRN + 2; i++) cyc("drop_mid_drain", 0, 0, 4'd0, 0);
    cyc("mac_reset", 0, 0, MAC_ALU, 0);
    cyc("mac_reset_busy", 0, 0, 4'd0, 0);
    @(negedge clk);
    drive(0, 0, 4'd0, 0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset", "ctl", ctl(), 7'd0);
    chk("async_reset", "state", bus.ctrl_state, 64'd0);
    chk("async_reset", "stall_cnt", bus.stall_cnt, 64'd0);
    chk("async_reset", "flush_cnt", bus.flush_cnt, 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc("after_reset", 0, 0, 4'd0, 0);
    h = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) h = !h;
      cyc("rand", $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0 ? MAC_ALU : 4'($urandom_range(0, 15)), h);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
